// File: rtl/drac_pkg.sv
// Shared types for the writeback/commit stage.
// Entry layout buffered between EXE and retirement.
package drac_pkg;

  localparam int XLEN    = 64;
  localparam int PC_W    = 40;
  localparam int CAUSE_W = 4;

  typedef struct packed {
    logic [4:0]         rd;
    logic               we;
    logic [XLEN-1:0]    result;
    logic [PC_W-1:0]    pc;
    logic               xcpt;
    logic [CAUSE_W-1:0] cause;
  } wb_entry_t;

  typedef enum logic {
    WB_RUN,
    WB_XCPT
  } wb_state_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of commit entries with flush and a
// two-port youngest-first bypass search.
module wb_fifo
  import drac_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            push_i,
  input  logic            pop_i,
  input  wb_entry_t       din_i,
  output wb_entry_t       head_o,
  output logic            empty_o,
  output logic            full_o,
  input  logic [4:0]      addr1_i,
  input  logic [4:0]      addr2_i,
  output logic            hit1_o,
  output logic            hit2_o,
  output logic [XLEN-1:0] data1_o,
  output logic [XLEN-1:0] data2_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

  wb_entry_t   mem_q [DEPTH];
  logic [AW:0] wptr_q;
  logic [AW:0] rptr_q;
  logic [AW:0] cnt;

  assign cnt     = wptr_q - rptr_q;
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                   (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign head_o  = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_i && !full_o) begin
        mem_q[wptr_q[AW-1:0]] <= din_i;
        wptr_q <= wptr_q + ONE;
      end
      if (pop_i && !empty_o) begin
        rptr_q <= rptr_q + ONE;
      end
    end
  end

  function automatic logic match(wb_entry_t e, logic [4:0] a);
    return (a != 5'd0) && (e.rd == a) && e.we && !e.xcpt;
  endfunction

  // Walk oldest to youngest so the last match (youngest) sticks.
  always_comb begin
    hit1_o  = 1'b0;
    hit2_o  = 1'b0;
    data1_o = '0;
    data2_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((AW+1)'(i) < cnt) begin
        if (match(mem_q[rptr_q[AW-1:0] + AW'(i)], addr1_i)) begin
          hit1_o  = 1'b1;
          data1_o = mem_q[rptr_q[AW-1:0] + AW'(i)].result;
        end
        if (match(mem_q[rptr_q[AW-1:0] + AW'(i)], addr2_i)) begin
          hit2_o  = 1'b1;
          data2_o = mem_q[rptr_q[AW-1:0] + AW'(i)].result;
        end
      end
    end
  end

endmodule

// File: rtl/wb_commit_stage.sv
// In-order writeback/commit: buffers EXE results, retires
// one per cycle, raises exceptions at commit, serves bypass.
module wb_commit_stage
  import drac_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               exe_valid_i,
  output logic               exe_ready_o,
  input  logic [4:0]         exe_rd_i,
  input  logic               exe_we_i,
  input  logic [XLEN-1:0]    exe_result_i,
  input  logic [PC_W-1:0]    exe_pc_i,
  input  logic               exe_xcpt_i,
  input  logic [CAUSE_W-1:0] exe_cause_i,
  output logic               rf_we_o,
  output logic [4:0]         rf_waddr_o,
  output logic [XLEN-1:0]    rf_wdata_o,
  output logic               commit_valid_o,
  output logic [PC_W-1:0]    commit_pc_o,
  output logic               xcpt_valid_o,
  output logic [PC_W-1:0]    xcpt_pc_o,
  output logic [CAUSE_W-1:0] xcpt_cause_o,
  input  logic               xcpt_ack_i,
  input  logic [4:0]         byp_addr1_i,
  input  logic [4:0]         byp_addr2_i,
  output logic               byp_hit1_o,
  output logic               byp_hit2_o,
  output logic [XLEN-1:0]    byp_data1_o,
  output logic [XLEN-1:0]    byp_data2_o,
  output logic [63:0]        instret_o
);

  wb_state_t          state_q;
  logic               rf_we_q;
  logic [4:0]         rf_waddr_q;
  logic [XLEN-1:0]    rf_wdata_q;
  logic               commit_valid_q;
  logic [PC_W-1:0]    commit_pc_q;
  logic               xcpt_valid_q;
  logic [PC_W-1:0]    xcpt_pc_q;
  logic [CAUSE_W-1:0] xcpt_cause_q;
  logic [63:0]        instret_q;

  wb_entry_t       din;
  wb_entry_t       head;
  logic            empty;
  logic            full;
  logic            run;
  logic            push;
  logic            pop;
  logic            kill;
  logic            fhit1;
  logic            fhit2;
  logic [XLEN-1:0] fdata1;
  logic [XLEN-1:0] fdata2;
  logic            rhit1;
  logic            rhit2;

  assign din = '{rd: exe_rd_i, we: exe_we_i,
                 result: exe_result_i, pc: exe_pc_i,
                 xcpt: exe_xcpt_i, cause: exe_cause_i};

  assign run         = (state_q == WB_RUN);
  assign exe_ready_o = run && !full && !rst_i;
  assign push        = exe_valid_i && exe_ready_o;
  assign pop         = run && !empty && !flush_i;
  // A faulting head also kills anything enqueued alongside it.
  assign kill        = flush_i || (pop && head.xcpt);

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (kill),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (din),
    .head_o  (head),
    .empty_o (empty),
    .full_o  (full),
    .addr1_i (byp_addr1_i),
    .addr2_i (byp_addr2_i),
    .hit1_o  (fhit1),
    .hit2_o  (fhit2),
    .data1_o (fdata1),
    .data2_o (fdata2)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= WB_RUN;
      rf_we_q        <= 1'b0;
      rf_waddr_q     <= '0;
      rf_wdata_q     <= '0;
      commit_valid_q <= 1'b0;
      commit_pc_q    <= '0;
      xcpt_valid_q   <= 1'b0;
      xcpt_pc_q      <= '0;
      xcpt_cause_q   <= '0;
      instret_q      <= '0;
    end else begin
      rf_we_q        <= 1'b0;
      commit_valid_q <= 1'b0;
      if (flush_i) begin
        state_q <= state_q;
      end else if (pop) begin
        if (head.xcpt) begin
          xcpt_valid_q <= 1'b1;
          xcpt_pc_q    <= head.pc;
          xcpt_cause_q <= head.cause;
          state_q      <= WB_XCPT;
        end else begin
          commit_valid_q <= 1'b1;
          commit_pc_q    <= head.pc;
          rf_we_q        <= head.we && (head.rd != 5'd0);
          rf_waddr_q     <= head.rd;
          rf_wdata_q     <= head.result;
          instret_q      <= instret_q + 64'd1;
        end
      end else if (!run && xcpt_ack_i) begin
        xcpt_valid_q <= 1'b0;
        state_q      <= WB_RUN;
      end
    end
  end

  // The output register is the oldest bypass source.
  assign rhit1 = rf_we_q && (rf_waddr_q == byp_addr1_i);
  assign rhit2 = rf_we_q && (rf_waddr_q == byp_addr2_i);

  assign byp_hit1_o  = fhit1 || rhit1;
  assign byp_hit2_o  = fhit2 || rhit2;
  assign byp_data1_o = fhit1 ? fdata1 : (rhit1 ? rf_wdata_q : '0);
  assign byp_data2_o = fhit2 ? fdata2 : (rhit2 ? rf_wdata_q : '0);

  assign rf_we_o        = rf_we_q;
  assign rf_waddr_o     = rf_waddr_q;
  assign rf_wdata_o     = rf_wdata_q;
  assign commit_valid_o = commit_valid_q;
  assign commit_pc_o    = commit_pc_q;
  assign xcpt_valid_o   = xcpt_valid_q;
  assign xcpt_pc_o      = xcpt_pc_q;
  assign xcpt_cause_o   = xcpt_cause_q;
  assign instret_o      = instret_q;

endmodule
